// File: rtl/block_pack_fifo.sv
// block_pack_fifo: packs DATA_W-bit words into blocks of WORDS words
// and buffers up to DEPTH complete blocks for the cipher core.
module block_pack_fifo #(
  parameter int DATA_W    = 32,
  parameter int WORDS     = 4,
  parameter int DEPTH     = 2,
  parameter int MSW_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         write_en,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         read_en,
  output logic [DATA_W*WORDS-1:0]      data_out,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic [$clog2(DEPTH+1)-1:0]   block_count,
  output logic [$clog2(WORDS)-1:0]     word_count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int BW = DATA_W * WORDS;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(WORDS);

  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WORDS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [BW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          rd_ok;
  logic          wr_ok;
  logic          wr_done;
  logic [CW-1:0] cnt_nxt;
  logic [BW-1:0] lane_mask;
  logic [BW-1:0] lane_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + 1'b1;
  endfunction

  // Lane mask selects where the current word lands inside the slot.
  for (genvar k = 0; k < WORDS; k++) begin : g_lane
    localparam int POS = (MSW_FIRST != 0) ? (WORDS - 1 - k) * DATA_W
                                          : k * DATA_W;
    assign lane_mask[POS +: DATA_W] =
      {DATA_W{word_count == WW'(k)}};
  end

  assign lane_data = {WORDS{data_in}};

  // Handshake decode; a write at full rides on a same-cycle pop.
  always_comb begin
    rd_ok   = read_en & ~fifo_empty;
    wr_ok   = write_en & (~fifo_full | rd_ok);
    wr_done = wr_ok & (word_count == W_LAST);
    cnt_nxt = block_count;
    if (wr_done & ~rd_ok)
      cnt_nxt = block_count + 1'b1;
    else if (~wr_done & rd_ok)
      cnt_nxt = block_count - 1'b1;
  end

  // Slot storage: assemble words in place in slot wr_ptr.
  always_ff @(posedge clk) begin
    if (~rst & ~clear & wr_ok)
      mem[wr_ptr] <= (mem[wr_ptr] & ~lane_mask)
                   | (lane_data & lane_mask);
  end

  // Pointers, counters, flags and output block register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      word_count  <= '0;
      block_count <= '0;
      fifo_empty  <= 1'b1;
      fifo_full   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      data_out    <= '0;
    end else if (clear) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      word_count  <= '0;
      block_count <= '0;
      fifo_empty  <= 1'b1;
      fifo_full   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      overflow  <= write_en & ~wr_ok;
      underflow <= read_en & fifo_empty;
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end
      if (wr_ok) begin
        word_count <= wr_done ? '0 : word_count + 1'b1;
        if (wr_done)
          wr_ptr <= ptr_inc(wr_ptr);
      end
      block_count <= cnt_nxt;
      fifo_empty  <= (cnt_nxt == '0);
      fifo_full   <= (cnt_nxt == C_FULL);
    end
  end

endmodule

// File: tb/tb_block_pack_fifo.sv
// tb_block_pack_fifo: directed scoreboard bench for block_pack_fifo
// across default and alternate parameter sets.
module tb_block_pack_fifo;

  typedef struct {
    logic [127:0] d;
    logic         unf;
  } exp_t;

  logic tb_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 tb_clk = ~tb_clk;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Instance 0: default parameters
  logic         clr0 = 0, we0 = 0, re0 = 0, rs0 = 0;
  logic [31:0]  din0 = '0;
  logic [127:0] dout0;
  logic         emp0, ful0, ovf0, unf0;
  logic [1:0]   bc0, wc0;

  block_pack_fifo u0 (
    .clk(tb_clk), .rst(rst), .clear(clr0), .write_en(we0),
    .data_in(din0), .read_en(re0), .data_out(dout0),
    .fifo_empty(emp0), .fifo_full(ful0), .block_count(bc0),
    .word_count(wc0), .overflow(ovf0), .underflow(unf0)
  );

  // Instance 1: LSW first, DEPTH=3
  logic         clr1 = 0, we1 = 0, re1 = 0, rs1 = 0;
  logic [31:0]  din1 = '0;
  logic [127:0] dout1;
  logic         emp1, ful1, ovf1, unf1;
  logic [1:0]   bc1, wc1;

  block_pack_fifo #(
    .DATA_W(32), .WORDS(4), .DEPTH(3), .MSW_FIRST(0)
  ) u1 (
    .clk(tb_clk), .rst(rst), .clear(clr1), .write_en(we1),
    .data_in(din1), .read_en(re1), .data_out(dout1),
    .fifo_empty(emp1), .fifo_full(ful1), .block_count(bc1),
    .word_count(wc1), .overflow(ovf1), .underflow(unf1)
  );

  // Instance 2: 8-bit words, 16 per block
  logic         clr2 = 0, we2 = 0, re2 = 0, rs2 = 0;
  logic [7:0]   din2 = '0;
  logic [127:0] dout2;
  logic         emp2, ful2, ovf2, unf2;
  logic [1:0]   bc2;
  logic [3:0]   wc2;

  block_pack_fifo #(
    .DATA_W(8), .WORDS(16), .DEPTH(2), .MSW_FIRST(1)
  ) u2 (
    .clk(tb_clk), .rst(rst), .clear(clr2), .write_en(we2),
    .data_in(din2), .read_en(re2), .data_out(dout2),
    .fifo_empty(emp2), .fifo_full(ful2), .block_count(bc2),
    .word_count(wc2), .overflow(ovf2), .underflow(unf2)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // Remember which cycles carried a read so the monitor knows
  // when a popped block is presented.
  always @(posedge tb_clk) begin
    rs0 <= re0 & ~rst & ~clr0;
    rs1 <= re1 & ~rst & ~clr1;
    rs2 <= re2 & ~rst & ~clr2;
  end

  // Monitor: pop expected block per presented read and compare.
  always @(negedge tb_clk) begin
    exp_t e;
    if (rs0) begin
      if (q0.size() == 0) begin
        chk("u0_unexpected_pop", 128'(1), 128'(0));
      end else begin
        e = q0.pop_front();
        chk("u0_data_out", dout0, e.d);
        chk("u0_underflow", 128'(unf0), 128'(e.unf));
      end
    end
    if (rs1) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_pop", 128'(1), 128'(0));
      end else begin
        e = q1.pop_front();
        chk("u1_data_out", dout1, e.d);
        chk("u1_underflow", 128'(unf1), 128'(e.unf));
      end
    end
    if (rs2) begin
      if (q2.size() == 0) begin
        chk("u2_unexpected_pop", 128'(1), 128'(0));
      end else begin
        e = q2.pop_front();
        chk("u2_data_out", dout2, e.d);
        chk("u2_underflow", 128'(unf2), 128'(e.unf));
      end
    end
  end

  task automatic wr0(input logic [31:0] v);
    we0  = 1'b1;
    din0 = v;
    step();
    we0  = 1'b0;
    step();
  endtask

  task automatic pop0(input logic [127:0] v, input logic u);
    exp_t e;
    e.d   = v;
    e.unf = u;
    q0.push_back(e);
    re0 = 1'b1;
    step();
    re0 = 1'b0;
  endtask

  task automatic expect1(input logic [127:0] v);
    exp_t e;
    e.d   = v;
    e.unf = 1'b0;
    q1.push_back(e);
  endtask

  localparam logic [127:0] BLK_A =
    128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  localparam logic [127:0] BLK_1 =
    128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_M =
    128'h12345678_BBBBBBBB_CCCCCCCC_DDDDDDDD;

  initial begin
    logic [31:0] w;
    exp_t e;

    repeat (2) step();
    rst = 1'b0;

    chk("rst_empty", 128'(emp0), 128'(1));
    chk("rst_full", 128'(ful0), 128'(0));
    chk("rst_bc", 128'(bc0), 128'(0));
    chk("rst_wc", 128'(wc0), 128'(0));
    chk("rst_dout", dout0, 128'(0));
    chk("rst_ovf", 128'(ovf0), 128'(0));
    chk("rst_unf", 128'(unf0), 128'(0));

    wr0(32'hAAAAAAAA);
    chk("wc_after_1", 128'(wc0), 128'(1));
    chk("empty_partial", 128'(emp0), 128'(1));
    wr0(32'hBBBBBBBB);
    wr0(32'hCCCCCCCC);
    wr0(32'hDDDDDDDD);
    chk("blk1_bc", 128'(bc0), 128'(1));
    chk("blk1_empty", 128'(emp0), 128'(0));
    chk("blk1_wc", 128'(wc0), 128'(0));

    wr0(32'h11111111);
    wr0(32'h22222222);
    wr0(32'h33333333);
    wr0(32'h44444444);
    chk("blk2_full", 128'(ful0), 128'(1));
    chk("blk2_bc", 128'(bc0), 128'(2));

    we0  = 1'b1;
    din0 = 32'hEEEEEEEE;
    step();
    we0  = 1'b0;
    chk("ovf_pulse", 128'(ovf0), 128'(1));
    chk("ovf_wc", 128'(wc0), 128'(0));
    chk("ovf_bc", 128'(bc0), 128'(2));
    step();
    chk("ovf_clear", 128'(ovf0), 128'(0));

    pop0(BLK_A, 1'b0);
    chk("pop1_bc", 128'(bc0), 128'(1));
    chk("pop1_full", 128'(ful0), 128'(0));
    pop0(BLK_1, 1'b0);
    chk("pop2_empty", 128'(emp0), 128'(1));
    chk("pop2_bc", 128'(bc0), 128'(0));

    wr0(32'hAAAAAAAA);
    wr0(32'hBBBBBBBB);
    wr0(32'hCCCCCCCC);
    wr0(32'hDDDDDDDD);
    wr0(32'h11111111);
    wr0(32'h22222222);
    wr0(32'h33333333);
    wr0(32'h44444444);
    chk("refill_full", 128'(ful0), 128'(1));

    e.d   = BLK_A;
    e.unf = 1'b0;
    q0.push_back(e);
    re0  = 1'b1;
    we0  = 1'b1;
    din0 = 32'h12345678;
    step();
    re0 = 1'b0;
    we0 = 1'b0;
    chk("rw_full_bc", 128'(bc0), 128'(1));
    chk("rw_full_wc", 128'(wc0), 128'(1));
    chk("rw_full_full", 128'(ful0), 128'(0));
    chk("rw_full_ovf", 128'(ovf0), 128'(0));
    wr0(32'hBBBBBBBB);
    wr0(32'hCCCCCCCC);
    wr0(32'hDDDDDDDD);
    chk("rw_refull", 128'(ful0), 128'(1));
    chk("rw_refull_bc", 128'(bc0), 128'(2));
    pop0(BLK_1, 1'b0);
    pop0(BLK_M, 1'b0);
    chk("drain_empty", 128'(emp0), 128'(1));

    pop0(BLK_M, 1'b1);
    chk("unf_pulse", 128'(unf0), 128'(1));
    step();
    chk("unf_clear", 128'(unf0), 128'(0));

    wr0(32'h55555555);
    wr0(32'h66666666);
    chk("pre_clear_wc", 128'(wc0), 128'(2));
    clr0 = 1'b1;
    we0  = 1'b1;
    din0 = 32'hFFFFFFFF;
    step();
    clr0 = 1'b0;
    we0  = 1'b0;
    chk("clear_wc", 128'(wc0), 128'(0));
    chk("clear_empty", 128'(emp0), 128'(1));
    chk("clear_bc", 128'(bc0), 128'(0));
    chk("clear_ovf", 128'(ovf0), 128'(0));
    chk("clear_dout", dout0, BLK_M);

    wr0(32'h77777777);
    chk("pre_rst_wc", 128'(wc0), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_wc", 128'(wc0), 128'(0));
    chk("rst_mid_empty", 128'(emp0), 128'(1));
    chk("rst_mid_dout", dout0, 128'(0));
    wr0(32'h01020304);
    wr0(32'h05060708);
    wr0(32'h090A0B0C);
    wr0(32'h0D0E0F10);
    pop0(128'h01020304_05060708_090A0B0C_0D0E0F10, 1'b0);

    // Instance 1: offset pointers first, then full fill/drain rounds
    for (int i = 1; i <= 4; i++) begin
      we1  = 1'b1;
      din1 = 32'h100 + 32'(i);
      step();
    end
    we1 = 1'b0;
    expect1(128'h00000104_00000103_00000102_00000101);
    re1 = 1'b1;
    step();
    re1 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 12; i++) begin
        we1  = 1'b1;
        din1 = 32'(r) * 32'h1000 + 32'(i);
        step();
      end
      we1 = 1'b0;
      chk("u1_full", 128'(ful1), 128'(1));
      chk("u1_bc", 128'(bc1), 128'(3));
      for (int j = 0; j < 3; j++) begin
        w = 32'(r) * 32'h1000 + 32'(4 * j);
        expect1({w + 32'd4, w + 32'd3, w + 32'd2, w + 32'd1});
      end
      re1 = 1'b1;
      repeat (3) step();
      re1 = 1'b0;
      chk("u1_empty", 128'(emp1), 128'(1));
      chk("u1_unf", 128'(unf1), 128'(0));
    end

    // Instance 2: sixteen byte writes make one block
    for (int i = 0; i < 16; i++) begin
      we2  = 1'b1;
      din2 = 8'(i);
      step();
      chk("u2_empty", 128'(emp2), 128'(i < 15));
      chk("u2_wc", 128'(wc2), 128'((i + 1) % 16));
    end
    we2 = 1'b0;
    e.d   = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    e.unf = 1'b0;
    q2.push_back(e);
    re2 = 1'b1;
    step();
    re2 = 1'b0;
    chk("u2_drain_empty", 128'(emp2), 128'(1));

    repeat (2) step();
    chk("queues_drained",
        128'(q0.size() + q1.size() + q2.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
